// File: rtl/cu_gen_pkg.sv
// Shared encodings for the generation-2 control unit: opcodes, FSM states
// and the datapath select codes it drives.
package cu_gen_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5,
        OP_LOADC = 4'd6,
        OP_JMP   = 4'd7,
        OP_JZ    = 4'd8
    } opcode_e;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9,
        ST_LOADC  = 4'd10,
        ST_JMP    = 4'd11,
        ST_JZ     = 4'd12
    } state_e;

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;

    localparam logic [1:0] RFS_ALU  = 2'b00;
    localparam logic [1:0] RFS_DMEM = 2'b01;
    localparam logic [1:0] RFS_IMM  = 2'b10;

endpackage

// File: rtl/pc_counter_gen.sv
// Program counter with clear, parallel load and increment (wraps modulo 2^PC_W).
module pc_counter_gen #(
    parameter int PC_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            inc,
    input  logic            ld,
    input  logic [PC_W-1:0] ld_val,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] r_pc;

    // PC register, priority clr > ld > inc
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= '0;
        end else if (clr) begin
            r_pc <= '0;
        end else if (ld) begin
            r_pc <= ld_val;
        end else if (inc) begin
            r_pc <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
        end else begin
            r_pc <= r_pc;
        end
    end

    assign pc = r_pc;

endmodule

// File: rtl/control_unit_gen.sv
// Fetch/decode/execute control unit: instruction-memory handshake, IR, PC and
// Moore decode of datapath controls from (state, IR).
module control_unit_gen
    import cu_gen_pkg::*;
#(
    parameter int IW    = 16,
    parameter int PC_W  = 7,
    parameter int RF_AW = 4,
    parameter int DM_AW = 8
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_valid,
    input  logic [IW-1:0]    imem_data,
    input  logic             alu_zero,
    input  logic             resume,
    output logic [DM_AW-1:0] D_addr,
    output logic             D_wr,
    output logic [1:0]       RF_s,
    output logic             RF_W_en,
    output logic [RF_AW-1:0] RF_Ra_addr,
    output logic [RF_AW-1:0] RF_Rb_addr,
    output logic [RF_AW-1:0] RF_W_addr,
    output logic [2:0]       ALU_s0,
    output logic [DM_AW-1:0] imm,
    output logic [PC_W-1:0]  PC_out,
    output logic [IW-1:0]    IR_out,
    output logic [3:0]       OutState,
    output logic [3:0]       NextState,
    output logic             illegal_op
);

    if ((4 + 3*RF_AW > IW) || (4 + DM_AW + RF_AW > IW) || (4 + RF_AW + PC_W > IW)) begin : g_param_check
        $fatal(1, "control_unit_gen: instruction fields do not fit in IW");
    end

    typedef struct packed {
        logic             imem_req;
        logic [DM_AW-1:0] d_addr;
        logic             d_wr;
        logic [1:0]       rf_s;
        logic             rf_w_en;
        logic [RF_AW-1:0] ra;
        logic [RF_AW-1:0] rb;
        logic [RF_AW-1:0] rw;
        logic [2:0]       alu_s;
        logic [DM_AW-1:0] imm;
        logic             illegal;
    } ctl_t;

    // Controls are a pure function of state and IR; evaluating it on the
    // next-cycle values lets the outputs come straight from flops.
    function automatic ctl_t decode_ctl(input state_e st, input logic [IW-1:0] ir);
        ctl_t c;
        c = '0;
        case (st)
            ST_FETCH:  c.imem_req = 1'b1;
            ST_DECODE: c.illegal  = (ir[IW-1 -: 4] > OP_JZ);
            ST_LOAD_A, ST_LOAD_B: begin
                c.d_addr  = ir[IW-5 -: DM_AW];
                c.rf_s    = RFS_DMEM;
                c.rw      = ir[RF_AW-1:0];
                c.rf_w_en = (st == ST_LOAD_B);
            end
            ST_STORE: begin
                c.d_addr = ir[IW-5 -: DM_AW];
                c.ra     = ir[RF_AW-1:0];
                c.alu_s  = ALU_PASS_A;
                c.d_wr   = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                c.ra      = ir[IW-5 -: RF_AW];
                c.rb      = ir[IW-5-RF_AW -: RF_AW];
                c.rw      = ir[RF_AW-1:0];
                c.alu_s   = (st == ST_ADD) ? ALU_ADD : ALU_SUB;
                c.rf_s    = RFS_ALU;
                c.rf_w_en = 1'b1;
            end
            ST_LOADC: begin
                c.imm     = ir[IW-5 -: DM_AW];
                c.rf_s    = RFS_IMM;
                c.rw      = ir[RF_AW-1:0];
                c.rf_w_en = 1'b1;
            end
            ST_JZ: begin
                c.ra    = ir[IW-5 -: RF_AW];
                c.alu_s = ALU_PASS_A;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_e          r_state;
    state_e          w_next_state;
    logic [IW-1:0]   r_ir;
    logic [IW-1:0]   w_ir_next;
    logic [3:0]      w_opcode;
    logic [PC_W-1:0] w_pc;
    logic            w_fetch_done;
    logic            w_pc_ld;
    ctl_t            r_ctl;

    assign w_opcode     = r_ir[IW-1 -: 4];
    assign w_fetch_done = (r_state == ST_FETCH) && imem_valid;
    assign w_pc_ld      = (r_state == ST_JMP) || ((r_state == ST_JZ) && alu_zero);

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT:   w_next_state = ST_FETCH;
            ST_FETCH:  w_next_state = imem_valid ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (w_opcode)
                    OP_NOOP:  w_next_state = ST_NOOP;
                    OP_STORE: w_next_state = ST_STORE;
                    OP_LOAD:  w_next_state = ST_LOAD_A;
                    OP_ADD:   w_next_state = ST_ADD;
                    OP_SUB:   w_next_state = ST_SUB;
                    OP_HALT:  w_next_state = ST_HALT;
                    OP_LOADC: w_next_state = ST_LOADC;
                    OP_JMP:   w_next_state = ST_JMP;
                    OP_JZ:    w_next_state = ST_JZ;
                    default:  w_next_state = ST_NOOP;
                endcase
            end
            ST_LOAD_A: w_next_state = ST_LOAD_B;
            ST_HALT:   w_next_state = resume ? ST_FETCH : ST_HALT;
            ST_NOOP, ST_LOAD_B, ST_STORE, ST_ADD, ST_SUB,
            ST_LOADC, ST_JMP, ST_JZ: w_next_state = ST_FETCH;
            default:   w_next_state = ST_INIT;
        endcase
    end

    // IR captures the fetched word only on the handshake edge
    always_comb begin
        if (w_fetch_done) begin
            w_ir_next = imem_data;
        end else begin
            w_ir_next = r_ir;
        end
    end

    // State, IR and registered control outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_INIT;
            r_ir    <= '0;
            r_ctl   <= '0;
        end else begin
            r_state <= w_next_state;
            r_ir    <= w_ir_next;
            r_ctl   <= decode_ctl(w_next_state, w_ir_next);
        end
    end

    pc_counter_gen #(.PC_W(PC_W)) u_pc (
        .clk    (clk),
        .reset  (reset),
        .clr    (r_state == ST_INIT),
        .inc    (w_fetch_done),
        .ld     (w_pc_ld),
        .ld_val (r_ir[PC_W-1:0]),
        .pc     (w_pc)
    );

    assign imem_req   = r_ctl.imem_req;
    assign imem_addr  = w_pc;
    assign D_addr     = r_ctl.d_addr;
    assign D_wr       = r_ctl.d_wr;
    assign RF_s       = r_ctl.rf_s;
    assign RF_W_en    = r_ctl.rf_w_en;
    assign RF_Ra_addr = r_ctl.ra;
    assign RF_Rb_addr = r_ctl.rb;
    assign RF_W_addr  = r_ctl.rw;
    assign ALU_s0     = r_ctl.alu_s;
    assign imm        = r_ctl.imm;
    assign PC_out     = w_pc;
    assign IR_out     = r_ir;
    assign OutState   = r_state;
    assign NextState  = w_next_state;
    assign illegal_op = r_ctl.illegal;

endmodule

// File: tb/tb_control_unit_gen.sv
// Scenario bench for control_unit_gen: an instruction-memory responder checks
// fetch addresses against a queue of expected fetches; tasks check state traces.
module tb_control_unit_gen;

    localparam int IW = 16, PC_W = 7, RF_AW = 4, DM_AW = 8;
    localparam logic [IW-1:0] I_HALT = 16'h5000;

    logic             clk = 1'b0;
    logic             reset;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_valid;
    logic [IW-1:0]    imem_data;
    logic             alu_zero;
    logic             resume;
    logic [DM_AW-1:0] D_addr;
    logic             D_wr;
    logic [1:0]       RF_s;
    logic             RF_W_en;
    logic [RF_AW-1:0] RF_Ra_addr, RF_Rb_addr, RF_W_addr;
    logic [2:0]       ALU_s0;
    logic [DM_AW-1:0] imm;
    logic [PC_W-1:0]  PC_out;
    logic [IW-1:0]    IR_out;
    logic [3:0]       OutState, NextState;
    logic             illegal_op;

    logic [IW-1:0] mem [0:127];
    int lat;
    int n_total = 0;
    int n_bad   = 0;
    int q_fetch[$];
    int q_state[$];

    control_unit_gen #(.IW(IW), .PC_W(PC_W), .RF_AW(RF_AW), .DM_AW(DM_AW)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data), .alu_zero(alu_zero),
        .resume(resume), .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s), .RF_W_en(RF_W_en),
        .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .RF_W_addr(RF_W_addr),
        .ALU_s0(ALU_s0), .imm(imm), .PC_out(PC_out), .IR_out(IR_out),
        .OutState(OutState), .NextState(NextState), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Memory model: answers a request after lat waiting cycles, checks the address
    task automatic imem_responder();
        int cnt = 0;
        int exp_a;
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1 && cnt >= lat) begin
                imem_valid = 1'b1;
                imem_data  = mem[imem_addr];
                cnt        = 0;
                n_total++;
                if (q_fetch.size() == 0) begin
                    n_bad++;
                    $display("FAIL fetch_addr unexpected fetch got=%0d", imem_addr);
                end else begin
                    exp_a = q_fetch.pop_front();
                    if (imem_addr !== exp_a[PC_W-1:0]) begin
                        n_bad++;
                        $display("FAIL fetch_addr got=%0d exp=%0d", imem_addr, exp_a);
                    end
                end
            end else if (imem_req === 1'b1) begin
                imem_valid = 1'b0;
                imem_data  = 16'hDEAD;
                cnt++;
            end else begin
                imem_valid = 1'b0;
                imem_data  = 16'hDEAD;
                cnt        = 0;
            end
        end
    endtask

    task automatic load_default();
        for (int i = 0; i < 128; i++) mem[i] = I_HALT;
        q_fetch.delete();
        q_state.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1;
        reset    = 1'b0;
        alu_zero = 1'b0;
        resume   = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        int exp_s;
        load_default();
        lat    = 0;
        mem[0] = 16'h20B1;
        apply_reset();
        n_total++;
        if ({imem_req, D_wr, RF_W_en, RF_s, ALU_s0, D_addr, RF_Ra_addr, RF_Rb_addr,
             RF_W_addr, imm, illegal_op} !== '0 || PC_out !== 7'd0 || IR_out !== 16'd0 ||
            OutState !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_state state=%0d pc=%0d ir=%h req=%b wen=%b", OutState, PC_out, IR_out, imem_req, RF_W_en);
        end
        q_fetch = '{0, 1};
        q_state = '{0, 1, 2, 4, 5, 1, 2, 9};
        reset = 1'b1;
        while (q_state.size() > 0) begin
            exp_s = q_state.pop_front();
            n_total++;
            if (OutState !== exp_s[3:0]) begin
                n_bad++;
                $display("FAIL reset_trace state got=%0d exp=%0d", OutState, exp_s);
            end
            if (exp_s == 4) begin
                n_total++;
                if (RF_W_en !== 1'b0 || RF_s !== 2'b01 || D_addr !== 8'd11) begin
                    n_bad++;
                    $display("FAIL load_a wen=%b rfs=%b daddr=%0d exp 0/01/11", RF_W_en, RF_s, D_addr);
                end
            end
            if (exp_s == 5) begin
                n_total++;
                if (D_addr !== 8'd11 || RF_W_addr !== 4'd1 || RF_s !== 2'b01 ||
                    RF_W_en !== 1'b1 || PC_out !== 7'd1) begin
                    n_bad++;
                    $display("FAIL load_b daddr=%0d w=%0d rfs=%b wen=%b pc=%0d exp 11/1/01/1/1",
                             D_addr, RF_W_addr, RF_s, RF_W_en, PC_out);
                end
            end
            step();
        end
        n_total++;
        if (q_fetch.size() != 0) begin
            n_bad++;
            $display("FAIL reset_fetches missing=%0d exp=0", q_fetch.size());
        end
    endtask

    task automatic test_latency();
        int guard;
        load_default();
        lat     = 3;
        mem[0]  = 16'h63C2;
        q_fetch = '{0, 1};
        apply_reset();
        reset = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (OutState !== 4'd1 || imem_req !== 1'b1 || imem_addr !== 7'd0 || IR_out !== 16'd0 ||
                RF_W_en !== 1'b0 || D_wr !== 1'b0 || illegal_op !== 1'b0 ||
                NextState !== ((k == 3) ? 4'd2 : 4'd1)) begin
                n_bad++;
                $display("FAIL wait_cycle[%0d] st=%0d nst=%0d req=%b addr=%0d ir=%h wen=%b",
                         k, OutState, NextState, imem_req, imem_addr, IR_out, RF_W_en);
            end
            step();
        end
        n_total++;
        if (OutState !== 4'd2 || IR_out !== 16'h63C2 || PC_out !== 7'd1) begin
            n_bad++;
            $display("FAIL latency_decode st=%0d ir=%h pc=%0d exp 2/63c2/1", OutState, IR_out, PC_out);
        end
        step();
        n_total++;
        if (OutState !== 4'd10 || imm !== 8'h3C || RF_s !== 2'b10 || RF_W_addr !== 4'd2 || RF_W_en !== 1'b1) begin
            n_bad++;
            $display("FAIL loadc st=%0d imm=%h rfs=%b w=%0d wen=%b exp 10/3c/10/2/1", OutState, imm, RF_s, RF_W_addr, RF_W_en);
        end
        guard = 0;
        while (OutState !== 4'd9 && guard < 20) begin
            step();
            guard++;
        end
        n_total++;
        if (OutState !== 4'd9 || q_fetch.size() != 0) begin
            n_bad++;
            $display("FAIL latency_halt st=%0d missing=%0d exp 9/0", OutState, q_fetch.size());
        end
    endtask

    task automatic test_alu();
        int exp_s;
        load_default();
        lat     = 0;
        mem[0]  = 16'h3560;
        mem[1]  = 16'h4145;
        q_fetch = '{0, 1, 2};
        q_state = '{0, 1, 2, 7, 1, 2, 8, 1, 2, 9};
        apply_reset();
        reset = 1'b1;
        while (q_state.size() > 0) begin
            exp_s = q_state.pop_front();
            n_total++;
            if (OutState !== exp_s[3:0]) begin
                n_bad++;
                $display("FAIL alu_trace state got=%0d exp=%0d", OutState, exp_s);
            end
            if (exp_s == 7) begin
                n_total++;
                if (ALU_s0 !== 3'b001 || RF_Ra_addr !== 4'd5 || RF_Rb_addr !== 4'd6 ||
                    RF_W_addr !== 4'd0 || RF_W_en !== 1'b1 || RF_s !== 2'b00) begin
                    n_bad++;
                    $display("FAIL add alu=%b ra=%0d rb=%0d w=%0d wen=%b exp 001/5/6/0/1", ALU_s0, RF_Ra_addr, RF_Rb_addr, RF_W_addr, RF_W_en);
                end
            end
            if (exp_s == 8) begin
                n_total++;
                if (ALU_s0 !== 3'b010 || RF_Ra_addr !== 4'd1 || RF_Rb_addr !== 4'd4 ||
                    RF_W_addr !== 4'd5 || RF_W_en !== 1'b1 || RF_s !== 2'b00) begin
                    n_bad++;
                    $display("FAIL sub alu=%b ra=%0d rb=%0d w=%0d wen=%b exp 010/1/4/5/1", ALU_s0, RF_Ra_addr, RF_Rb_addr, RF_W_addr, RF_W_en);
                end
            end
            step();
        end
        n_total++;
        if (q_fetch.size() != 0) begin
            n_bad++;
            $display("FAIL alu_fetches missing=%0d exp=0", q_fetch.size());
        end
    endtask

    task automatic test_branch();
        int exp_s;
        int prev_s;
        for (int z = 0; z < 2; z++) begin
            load_default();
            lat      = 0;
            mem[0]   = 16'h6A53;
            mem[1]   = 16'h8310;
            mem[16]  = 16'h707F;
            if (z == 0) begin
                q_fetch = '{0, 1, 2};
                q_state = '{0, 1, 2, 10, 1, 2, 12, 1, 2, 9};
            end else begin
                q_fetch = '{0, 1, 16, 127};
                q_state = '{0, 1, 2, 10, 1, 2, 12, 1, 2, 11, 1, 2, 9};
            end
            apply_reset();
            alu_zero = (z == 1);
            reset    = 1'b1;
            prev_s   = -1;
            while (q_state.size() > 0) begin
                exp_s = q_state.pop_front();
                n_total++;
                if (OutState !== exp_s[3:0]) begin
                    n_bad++;
                    $display("FAIL branch%0d_trace state got=%0d exp=%0d", z, OutState, exp_s);
                end
                if (exp_s == 10) begin
                    n_total++;
                    if (imm !== 8'hA5 || RF_W_addr !== 4'd3 || RF_s !== 2'b10 || RF_W_en !== 1'b1) begin
                        n_bad++;
                        $display("FAIL loadc_a5 imm=%h w=%0d rfs=%b exp a5/3/10", imm, RF_W_addr, RF_s);
                    end
                end
                if (exp_s == 12) begin
                    n_total++;
                    if (RF_Ra_addr !== 4'd3 || ALU_s0 !== 3'b000 || RF_W_en !== 1'b0 || D_wr !== 1'b0) begin
                        n_bad++;
                        $display("FAIL jz_ctl ra=%0d alu=%b wen=%b exp 3/000/0", RF_Ra_addr, ALU_s0, RF_W_en);
                    end
                end
                if (prev_s == 12) begin
                    n_total++;
                    if (PC_out !== ((z == 1) ? 7'h10 : 7'd2)) begin
                        n_bad++;
                        $display("FAIL jz%0d_pc got=%0d exp=%0d", z, PC_out, (z == 1) ? 16 : 2);
                    end
                end
                if (prev_s == 11) begin
                    n_total++;
                    if (imem_addr !== 7'd127) begin
                        n_bad++;
                        $display("FAIL jmp_target got=%0d exp=127", imem_addr);
                    end
                end
                prev_s = exp_s;
                step();
            end
            if (z == 1) begin
                n_total++;
                if (PC_out !== 7'd0) begin
                    n_bad++;
                    $display("FAIL pc_wrap got=%0d exp=0", PC_out);
                end
                q_fetch.push_back(0);
                resume = 1'b1;
                step();
                resume = 1'b0;
            end
            n_total++;
            if (q_fetch.size() != 0) begin
                n_bad++;
                $display("FAIL branch%0d_fetches missing=%0d exp=0", z, q_fetch.size());
            end
        end
    endtask

    task automatic test_illegal();
        int exp_s;
        int k;
        int pulses;
        logic we_seen;
        load_default();
        lat     = 0;
        mem[0]  = 16'hF000;
        q_fetch = '{0, 1};
        q_state = '{0, 1, 2, 3, 1, 2, 9};
        apply_reset();
        reset   = 1'b1;
        k       = 0;
        pulses  = 0;
        we_seen = 1'b0;
        while (q_state.size() > 0) begin
            exp_s = q_state.pop_front();
            n_total++;
            if (OutState !== exp_s[3:0]) begin
                n_bad++;
                $display("FAIL illegal_trace state got=%0d exp=%0d", OutState, exp_s);
            end
            if (k == 2) begin
                n_total++;
                if (illegal_op !== 1'b1 || NextState !== 4'd3) begin
                    n_bad++;
                    $display("FAIL illegal_flag flag=%b nst=%0d exp 1/3", illegal_op, NextState);
                end
            end
            if (illegal_op === 1'b1) pulses++;
            if (RF_W_en !== 1'b0 || D_wr !== 1'b0) we_seen = 1'b1;
            k++;
            step();
        end
        n_total++;
        if (pulses != 1 || we_seen !== 1'b0 || q_fetch.size() != 0) begin
            n_bad++;
            $display("FAIL illegal_pulse pulses=%0d we=%b missing=%0d exp 1/0/0", pulses, we_seen, q_fetch.size());
        end
    endtask

    task automatic test_halt();
        int guard;
        load_default();
        lat = 0;
        for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
        mem[9] = 16'h6117;
        for (int i = 0; i <= 10; i++) q_fetch.push_back(i);
        apply_reset();
        reset = 1'b1;
        guard = 0;
        while (OutState !== 4'd9 && guard < 60) begin
            step();
            guard++;
        end
        n_total++;
        if (OutState !== 4'd9 || PC_out !== 7'd9) begin
            n_bad++;
            $display("FAIL halt_reach st=%0d pc=%0d exp 9/9", OutState, PC_out);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            n_total++;
            if (OutState !== 4'd9 || PC_out !== 7'd9 || imem_req !== 1'b0) begin
                n_bad++;
                $display("FAIL halt_hold[%0d] st=%0d pc=%0d req=%b", c, OutState, PC_out, imem_req);
            end
        end
        resume = 1'b1;
        #1;
        n_total++;
        if (NextState !== 4'd1) begin
            n_bad++;
            $display("FAIL resume_next got=%0d exp=1", NextState);
        end
        step();
        resume = 1'b0;
        n_total++;
        if (OutState !== 4'd1 || imem_addr !== 7'd9) begin
            n_bad++;
            $display("FAIL resume_fetch st=%0d addr=%0d exp 1/9", OutState, imem_addr);
        end
        guard = 0;
        while (OutState !== 4'd10 && guard < 5) begin
            step();
            guard++;
        end
        n_total++;
        if (OutState !== 4'd10 || imm !== 8'h11 || RF_W_addr !== 4'd7) begin
            n_bad++;
            $display("FAIL resume_loadc st=%0d imm=%h w=%0d exp 10/11/7", OutState, imm, RF_W_addr);
        end
        guard = 0;
        while (OutState !== 4'd9 && guard < 10) begin
            step();
            guard++;
        end
        n_total++;
        if (OutState !== 4'd9 || q_fetch.size() != 0) begin
            n_bad++;
            $display("FAIL halt_end st=%0d missing=%0d exp 9/0", OutState, q_fetch.size());
        end
    endtask

    task automatic test_reset_mid();
        load_default();
        lat     = 0;
        mem[0]  = 16'h2224;
        q_fetch = '{0};
        apply_reset();
        reset = 1'b1;
        step();
        step();
        step();
        n_total++;
        if (OutState !== 4'd4 || D_addr !== 8'h22 || RF_W_addr !== 4'd4 || RF_s !== 2'b01) begin
            n_bad++;
            $display("FAIL mid_load_a st=%0d daddr=%h w=%0d rfs=%b exp 4/22/4/01", OutState, D_addr, RF_W_addr, RF_s);
        end
        reset = 1'b0;
        #1;
        n_total++;
        if ({imem_req, D_wr, RF_W_en, RF_s, ALU_s0, D_addr, RF_Ra_addr, RF_Rb_addr,
             RF_W_addr, imm, illegal_op} !== '0 || PC_out !== 7'd0 || IR_out !== 16'd0 ||
            OutState !== 4'd0) begin
            n_bad++;
            $display("FAIL mid_reset st=%0d pc=%0d ir=%h daddr=%h w=%0d rfs=%b exp all 0",
                     OutState, PC_out, IR_out, D_addr, RF_W_addr, RF_s);
        end
        step();
        reset = 1'b1;
        n_total++;
        if (q_fetch.size() != 0) begin
            n_bad++;
            $display("FAIL mid_fetches missing=%0d exp=0", q_fetch.size());
        end
    endtask

    initial begin
        reset      = 1'b0;
        imem_valid = 1'b0;
        imem_data  = 16'hDEAD;
        alu_zero   = 1'b0;
        resume     = 1'b0;
        lat        = 0;
        fork
            imem_responder();
        join_none
        test_reset();
        test_latency();
        test_alu();
        test_branch();
        test_illegal();
        test_halt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
